seg7_scan: RTL and testbench

Eight-digit multiplexed seven-segment display driver, directly downstream of the board clock divider. It consumes the divider's one-cycle scan pulse and steps through the digits of a 32-bit hex value (PC, register or bus data from the CPU debug path). It drives active-low anode, segment and decimal-point lines. A one-cycle blanking gap between digits suppresses ghosting, and the displayed value is captured once per frame so digits never tear.

---
 rtl/seg7_scan.sv | 118 +++++++++++
 tb/tb_seg7_scan.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed 7-segment scanner: one digit per tick with a one-cycle blank gap,
// and the display value captured once per frame on the 7->0 wrap.
module seg7_scan (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  en_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic {ST_DRIVE, ST_BLANK} state_t;

  state_t      r_st, w_st_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [31:0] r_sh_data, w_sh_data_nxt;
  logic [7:0]  r_sh_dp, w_sh_dp_nxt;
  logic [7:0]  r_sh_en, w_sh_en_nxt;
  logic [7:0]  r_an, w_an_nxt;
  logic [6:0]  r_seg, w_seg_nxt;
  logic        r_dp, w_dp_nxt;

  logic [2:0]  w_new_idx;
  logic        w_wrap;
  logic [31:0] w_src_data;
  logic [7:0]  w_src_dp;
  logic [3:0]  w_nib;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'h40;
      4'h1: hex2seg = 7'h79;
      4'h2: hex2seg = 7'h24;
      4'h3: hex2seg = 7'h30;
      4'h4: hex2seg = 7'h19;
      4'h5: hex2seg = 7'h12;
      4'h6: hex2seg = 7'h02;
      4'h7: hex2seg = 7'h78;
      4'h8: hex2seg = 7'h00;
      4'h9: hex2seg = 7'h10;
      4'hA: hex2seg = 7'h08;
      4'hB: hex2seg = 7'h03;
      4'hC: hex2seg = 7'h46;
      4'hD: hex2seg = 7'h21;
      4'hE: hex2seg = 7'h06;
      default: hex2seg = 7'h0E;
    endcase
  endfunction

  assign w_new_idx  = r_idx + 3'd1;
  assign w_wrap     = (r_idx == 3'd7);
  // Digit 0 decodes from the live inputs because the shadows load on the same edge.
  assign w_src_data = w_wrap ? data    : r_sh_data;
  assign w_src_dp   = w_wrap ? dp_mask : r_sh_dp;
  assign w_nib      = w_src_data[{w_new_idx, 2'b00} +: 4];

  always_comb begin
    w_st_nxt      = r_st;
    w_idx_nxt     = r_idx;
    w_sh_data_nxt = r_sh_data;
    w_sh_dp_nxt   = r_sh_dp;
    w_sh_en_nxt   = r_sh_en;
    w_an_nxt      = r_an;
    w_seg_nxt     = r_seg;
    w_dp_nxt      = r_dp;
    case (r_st)
      ST_DRIVE: begin
        if (tick) begin
          w_idx_nxt = w_new_idx;
          w_an_nxt  = 8'hFF;
          w_seg_nxt = hex2seg(w_nib);
          w_dp_nxt  = ~w_src_dp[w_new_idx];
          w_st_nxt  = ST_BLANK;
          if (w_wrap) begin
            w_sh_data_nxt = data;
            w_sh_dp_nxt   = dp_mask;
            w_sh_en_nxt   = en_mask;
          end
        end
      end
      ST_BLANK: begin
        w_an_nxt = r_sh_en[r_idx] ? ~(8'b1 << r_idx) : 8'hFF;
        w_st_nxt = ST_DRIVE;
      end
      default: w_st_nxt = ST_DRIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st      <= ST_DRIVE;
      r_idx     <= 3'd7;
      r_sh_data <= 32'h0;
      r_sh_dp   <= 8'h0;
      r_sh_en   <= 8'h0;
      r_an      <= 8'hFF;
      r_seg     <= 7'h7F;
      r_dp      <= 1'b1;
    end else begin
      r_st      <= w_st_nxt;
      r_idx     <= w_idx_nxt;
      r_sh_data <= w_sh_data_nxt;
      r_sh_dp   <= w_sh_dp_nxt;
      r_sh_en   <= w_sh_en_nxt;
      r_an      <= w_an_nxt;
      r_seg     <= w_seg_nxt;
      r_dp      <= w_dp_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: reset, full frame decode, frame capture, enable mask,
// back-to-back ticks and mid-frame reset, checked with immediate assertions.
module tb_seg7_scan;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic [31:0] data;
  logic [7:0]  dp_mask;
  logic [7:0]  en_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .data    (data),
    .dp_mask (dp_mask),
    .en_mask (en_mask),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One scan step with 10-cycle spacing: blank on the tick edge, anode one cycle later, held to the end.
  task automatic do_tick(input string tag, input logic [6:0] s, input logic d, input logic [7:0] a);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk({tag, " an@T"}, {24'h0, an}, 32'hFF);
    chk({tag, " seg"}, {25'h0, seg}, {25'h0, s});
    chk({tag, " dp"}, {31'h0, dp}, {31'h0, d});
    step();
    chk({tag, " an@T+1"}, {24'h0, an}, {24'h0, a});
    for (int k = 0; k < 8; k++) step();
    chk({tag, " an hold"}, {24'h0, an}, {24'h0, a});
    chk({tag, " seg hold"}, {25'h0, seg}, {25'h0, s});
  endtask

  initial begin
    rst_n   = 1'b0;
    tick    = 1'b0;
    data    = 32'h0;
    dp_mask = 8'h0;
    en_mask = 8'hFF;

    // Reset held 3 cycles with tick toggling
    for (int i = 0; i < 3; i++) begin
      tick = ~tick;
      step();
      chk("rst an", {24'h0, an}, 32'hFF);
      chk("rst seg", {25'h0, seg}, 32'h7F);
      chk("rst dp", {31'h0, dp}, 32'h1);
    end
    tick  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("idle an", {24'h0, an}, 32'hFF);

    // Full frame
    data    = 32'h0123_89AB;
    dp_mask = 8'h01;
    en_mask = 8'hFF;
    do_tick("f1 d0", 7'h03, 1'b0, 8'hFE);
    do_tick("f1 d1", 7'h08, 1'b1, 8'hFD);
    do_tick("f1 d2", 7'h10, 1'b1, 8'hFB);
    do_tick("f1 d3", 7'h00, 1'b1, 8'hF7);
    do_tick("f1 d4", 7'h30, 1'b1, 8'hEF);
    do_tick("f1 d5", 7'h24, 1'b1, 8'hDF);
    do_tick("f1 d6", 7'h79, 1'b1, 8'hBF);
    do_tick("f1 d7", 7'h40, 1'b1, 8'h7F);

    // Frame capture: mid-frame change invisible until the next wrap
    do_tick("f2 d0", 7'h03, 1'b0, 8'hFE);
    do_tick("f2 d1", 7'h08, 1'b1, 8'hFD);
    do_tick("f2 d2", 7'h10, 1'b1, 8'hFB);
    data = 32'hFFFF_FFFF;
    do_tick("f2 d3", 7'h00, 1'b1, 8'hF7);
    do_tick("f2 d4", 7'h30, 1'b1, 8'hEF);
    do_tick("f2 d5", 7'h24, 1'b1, 8'hDF);
    do_tick("f2 d6", 7'h79, 1'b1, 8'hBF);
    do_tick("f2 d7", 7'h40, 1'b1, 8'h7F);
    do_tick("f3 d0", 7'h0E, 1'b0, 8'hFE);
    do_tick("f3 d1", 7'h0E, 1'b1, 8'hFD);
    do_tick("f3 d2", 7'h0E, 1'b1, 8'hFB);
    do_tick("f3 d3", 7'h0E, 1'b1, 8'hF7);
    do_tick("f3 d4", 7'h0E, 1'b1, 8'hEF);
    do_tick("f3 d5", 7'h0E, 1'b1, 8'hDF);
    do_tick("f3 d6", 7'h0E, 1'b1, 8'hBF);
    do_tick("f3 d7", 7'h0E, 1'b1, 8'h7F);

    // Enable mask: low four digits dark, segments still cycle
    data    = 32'h0123_89AB;
    en_mask = 8'hF0;
    do_tick("f4 d0", 7'h03, 1'b0, 8'hFF);
    do_tick("f4 d1", 7'h08, 1'b1, 8'hFF);
    do_tick("f4 d2", 7'h10, 1'b1, 8'hFF);
    do_tick("f4 d3", 7'h00, 1'b1, 8'hFF);
    do_tick("f4 d4", 7'h30, 1'b1, 8'hEF);
    do_tick("f4 d5", 7'h24, 1'b1, 8'hDF);
    do_tick("f4 d6", 7'h79, 1'b1, 8'hBF);
    do_tick("f4 d7", 7'h40, 1'b1, 8'h7F);

    // Back-to-back ticks: second one lands in BLANK and is dropped
    en_mask = 8'hFF;
    tick = 1'b1;
    step();
    chk("b2b an@T", {24'h0, an}, 32'hFF);
    chk("b2b seg@T", {25'h0, seg}, 32'h03);
    step();
    tick = 1'b0;
    chk("b2b an@T+1", {24'h0, an}, 32'hFE);
    chk("b2b seg@T+1", {25'h0, seg}, 32'h03);
    for (int k = 0; k < 8; k++) step();
    chk("b2b an hold", {24'h0, an}, 32'hFE);
    do_tick("b2b d1", 7'h08, 1'b1, 8'hFD);
    do_tick("b2b d2", 7'h10, 1'b1, 8'hFB);
    do_tick("b2b d3", 7'h00, 1'b1, 8'hF7);
    do_tick("b2b d4", 7'h30, 1'b1, 8'hEF);
    do_tick("b2b d5", 7'h24, 1'b1, 8'hDF);

    // Reset while digit 5 is lit, then fresh capture on the next tick
    data    = 32'h4567_CDEF;
    dp_mask = 8'h80;
    rst_n   = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst an", {24'h0, an}, 32'hFF);
    chk("mrst seg", {25'h0, seg}, 32'h7F);
    chk("mrst dp", {31'h0, dp}, 32'h1);
    for (int k = 0; k < 3; k++) step();
    chk("mrst idle an", {24'h0, an}, 32'hFF);
    do_tick("mrst d0", 7'h0E, 1'b1, 8'hFE);
    do_tick("mrst d1", 7'h06, 1'b1, 8'hFD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
